// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display source scheduler.
//   state_t : scheduler states ROTATE/HOLD/FIXED/FROZEN (codes visible in STATUS)
//   src_t   : display sources SRC_CPU/SRC_PC/SRC_DBG (codes visible on disp_src)
//   REG_*   : register selectors, compared against bus_addr[3:2]
//   CTRL_*  : bit positions inside the CTRL register
package disp_pkg;

   typedef enum logic [1:0] {
      ROTATE = 2'd0,
      HOLD   = 2'd1,
      FIXED  = 2'd2,
      FROZEN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SRC_CPU = 2'd0,
      SRC_PC  = 2'd1,
      SRC_DBG = 2'd2
   } src_t;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;

   localparam int unsigned CTRL_MODE_LSB = 0;
   localparam int unsigned CTRL_MODE_MSB = 1;
   localparam int unsigned CTRL_FREEZE   = 2;

   // Auto-rotate order: CPU -> PC -> DBG -> CPU.
   function automatic src_t src_advance(input src_t s);
      case (s)
         SRC_CPU: return SRC_PC;
         SRC_PC:  return SRC_DBG;
         default: return SRC_CPU;
      endcase
   endfunction

endpackage

// File: rtl/disp_term_cnt.sv
// disp_term_cnt: 32-bit up-counter with terminal-count flag.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : count enable
//   tc       : high while the count equals LIMIT-1
module disp_term_cnt #(
   parameter int unsigned LIMIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [31:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 32'd1;
   end

   assign tc = (cnt == 32'(LIMIT - 1));

endmodule

// File: rtl/disp_src_sched.sv
// disp_src_sched: chooses which 32-bit source drives the seven-segment
// display scanner (CPU register, live PC or debug word) and when to switch.
//   clk, rst     : clock, asynchronous active-low reset
//   bus_we/re    : one-cycle write/read strobes; bus_addr[3:2] selects
//                  DATA (0x0), CTRL (0x4), STATUS (0x8); 0xC reads 0
//   bus_wdata    : write data
//   bus_rdata    : read data, valid the cycle after bus_re (held until next read)
//   src_pc/dbg   : live source words, sampled every cycle
//   disp_data    : registered display word
//   disp_src     : current source (0 CPU, 1 PC, 2 DBG)
//   disp_upd     : high in the cycle disp_data shows a new value
//   disp_blank   : blank request after a source switch
// Optional: define DISP_BLANK_EN to enable the blank generator; otherwise
// disp_blank is tied low.
module disp_src_sched
   import disp_pkg::*;
#(
   parameter int unsigned DWELL     = 200000000,
   parameter int unsigned HOLD      = 300000000,
   parameter int unsigned BLANK_CYC = 10000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic [31:0] src_pc,
   input  logic [31:0] src_dbg,
   output logic [31:0] disp_data,
   output logic [1:0]  disp_src,
   output logic        disp_upd,
   output logic        disp_blank
);

   state_t      state, state_nxt;
   src_t        src, src_nxt;
   logic [31:0] cpu_reg;
   logic [2:0]  ctrl;
   logic [31:0] disp_data_nxt;
   logic [31:0] rd_mux;
   logic        wr_data, wr_ctrl, frozen_nxt;
   logic        dwell_clr, dwell_en, dwell_tc;
   logic        hold_clr, hold_en, hold_tc;
   logic        unused_addr;

   assign unused_addr = ^bus_addr[1:0];
   assign wr_data     = bus_we && (bus_addr[3:2] == REG_DATA);
   assign wr_ctrl     = bus_we && (bus_addr[3:2] == REG_CTRL);
   assign frozen_nxt  = (state_nxt == FROZEN);
   assign disp_src    = src;

   disp_term_cnt #(.LIMIT(DWELL)) u_dwell_cnt (
      .clk(clk), .rst(rst), .clr(dwell_clr), .en(dwell_en), .tc(dwell_tc)
   );

   disp_term_cnt #(.LIMIT(HOLD)) u_hold_cnt (
      .clk(clk), .rst(rst), .clr(hold_clr), .en(hold_en), .tc(hold_tc)
   );

   // The HOLD parameter shadows the imported state name, so the state is
   // always referenced with its package scope.
   always_comb begin
      state_nxt = state;
      src_nxt   = src;
      dwell_clr = 1'b0;
      dwell_en  = 1'b0;
      hold_clr  = 1'b0;
      hold_en   = 1'b0;
      if (ctrl[CTRL_FREEZE]) begin
         state_nxt = FROZEN;
      end else if (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] != 2'b00) begin
         state_nxt = FIXED;
         src_nxt   = src_t'(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] - 2'd1);
      end else begin
         case (state)
            ROTATE: begin
               if (wr_data) begin
                  state_nxt = disp_pkg::HOLD;
                  src_nxt   = SRC_CPU;
                  hold_clr  = 1'b1;
               end else if (dwell_tc) begin
                  src_nxt   = src_advance(src);
                  dwell_clr = 1'b1;
               end else begin
                  dwell_en  = 1'b1;
               end
            end
            disp_pkg::HOLD: begin
               if (wr_data) begin
                  hold_clr  = 1'b1;
               end else if (hold_tc) begin
                  state_nxt = ROTATE;
                  src_nxt   = SRC_CPU;
                  dwell_clr = 1'b1;
               end else begin
                  hold_en   = 1'b1;
               end
            end
            default: begin
               state_nxt = ROTATE;
               src_nxt   = SRC_CPU;
               dwell_clr = 1'b1;
            end
         endcase
      end
      // Every state change restarts both timers, so neither can wrap.
      if (state_nxt != state) begin
         dwell_clr = 1'b1;
         hold_clr  = 1'b1;
      end
   end

   always_comb begin
      case (src_nxt)
         SRC_CPU: disp_data_nxt = cpu_reg;
         SRC_PC:  disp_data_nxt = src_pc;
         default: disp_data_nxt = src_dbg;
      endcase
   end

   always_comb begin
      case (bus_addr[3:2])
         REG_DATA:   rd_mux = cpu_reg;
         REG_CTRL:   rd_mux = {29'b0, ctrl};
         REG_STATUS: rd_mux = {28'b0, state, src};
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ROTATE;
         src       <= SRC_CPU;
         cpu_reg   <= '0;
         ctrl      <= '0;
         disp_data <= '0;
         disp_upd  <= 1'b0;
         bus_rdata <= '0;
      end else begin
         state <= state_nxt;
         // Source and display word are latched on the edge into FROZEN
         // and held for as long as the freeze lasts.
         if (!frozen_nxt) begin
            src       <= src_nxt;
            disp_data <= disp_data_nxt;
         end
         disp_upd <= !frozen_nxt && (disp_data_nxt != disp_data);
         if (wr_data) cpu_reg <= bus_wdata;
         if (wr_ctrl) ctrl <= bus_wdata[2:0];
         if (bus_re)  bus_rdata <= rd_mux;
      end
   end

`ifdef DISP_BLANK_EN
   logic src_chg, blank_tc;

   assign src_chg = !frozen_nxt && (src_nxt != src);

   disp_term_cnt #(.LIMIT(BLANK_CYC)) u_blank_cnt (
      .clk(clk), .rst(rst), .clr(src_chg), .en(disp_blank), .tc(blank_tc)
   );

   // A switch during an active blank clears the counter, restarting it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         disp_blank <= 1'b0;
      else if (src_chg)
         disp_blank <= 1'b1;
      else if (blank_tc)
         disp_blank <= 1'b0;
   end
`else
   localparam int unsigned BLANK_UNUSED = BLANK_CYC;
   assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_disp_src_sched.sv
// tb_disp_src_sched: scoreboard bench for disp_src_sched (DWELL=8, HOLD=20,
// BLANK_CYC=3). Stimulus pushes expected display updates {data, src, cycle}
// and read results; a negedge monitor pops them when disp_upd / read data
// appear and also tracks the expected disp_blank waveform.
module tb_disp_src_sched;

   localparam int unsigned P_DWELL = 8;
   localparam int unsigned P_HOLD  = 20;
   localparam int unsigned P_BLANK = 3;
`ifdef DISP_BLANK_EN
   localparam int BLANK_MODEL = 3;
`else
   localparam int BLANK_MODEL = 0;
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  src;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_we, bus_re;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic [31:0] src_pc, src_dbg;
   logic [31:0] disp_data;
   logic [1:0]  disp_src;
   logic        disp_upd, disp_blank;

   int          cyc = 0;
   logic        rd_seen = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   ev_t         exp_q[$];
   logic [31:0] rd_q[$];
   logic [1:0]  prev_src = 2'd0;
   int          blank_left = 0;

   disp_src_sched #(
      .DWELL(P_DWELL),
      .HOLD(P_HOLD),
      .BLANK_CYC(P_BLANK)
   ) dut (
      .clk(clk), .rst(rst),
      .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .src_pc(src_pc), .src_dbg(src_dbg),
      .disp_data(disp_data), .disp_src(disp_src),
      .disp_upd(disp_upd), .disp_blank(disp_blank)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_seen <= bus_re;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: display-update scoreboard, read scoreboard, blank model.
   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         if (disp_upd) begin
            if (exp_q.size() == 0) begin
               check32("upd_unexpected", 32'(disp_upd), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check32("upd_cycle", 32'(cyc), 32'(e.cyc));
               check32("upd_data", disp_data, e.data);
               check32("upd_src", 32'(disp_src), 32'(e.src));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check32("upd_missing", 32'(disp_upd), 32'd1);
         end
         if (rd_seen && rd_q.size() > 0)
            check32("rd_data", bus_rdata, rd_q.pop_front());
         if (disp_src != prev_src) blank_left = BLANK_MODEL;
         check32("blank", 32'(disp_blank), (blank_left > 0) ? 32'd1 : 32'd0);
         if (blank_left > 0) blank_left--;
         prev_src = disp_src;
      end else begin
         prev_src   = 2'd0;
         blank_left = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] s, input int c);
      ev_t e;
      e.data = d;
      e.src  = s;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus_we    = 1'b1;
      bus_addr  = a;
      bus_wdata = d;
      tick();
      bus_we    = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
      rd_q.push_back(exp);
      bus_re   = 1'b1;
      bus_addr = a;
      tick();
      bus_re   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, w, x, y, f, g, h, k0;
      rst = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
      bus_addr = 4'h0; bus_wdata = '0;
      src_pc = 32'h1000; src_dbg = 32'hBEEF;
      repeat (3) tick();
      check32("rst_data", disp_data, 32'h0);
      check32("rst_src", 32'(disp_src), 32'h0);
      check32("rst_upd", 32'(disp_upd), 32'h0);
      check32("rst_blank", 32'(disp_blank), 32'h0);
      check32("rst_rdata", bus_rdata, 32'h0);

      // Auto rotation from reset.
      rst = 1'b1;
      c0 = cyc;
      push(32'h1000, 2'd1, c0 + 8);
      push(32'hBEEF, 2'd2, c0 + 16);
      push(32'h0,    2'd0, c0 + 24);
      push(32'h1000, 2'd1, c0 + 32);

      // DATA write mid-dwell on PC, re-write 10 cycles into HOLD.
      wait_until(c0 + 36);
      w = c0 + 37;
      push(32'h0,        2'd0, w);
      push(32'h12345678, 2'd0, w + 1);
      bus_write(4'h0, 32'h12345678);
      wait_until(w + 2);
      bus_read(4'h8, 32'h4);
      wait_until(w + 9);
      push(32'hCAFEF00D, 2'd0, w + 11);
      push(32'h1000,     2'd1, w + 38);
      push(32'hBEEF,     2'd2, w + 46);
      bus_write(4'h0, 32'hCAFEF00D);

      // Fixed PC: disp_data follows a changing PC with one cycle of lag.
      wait_until(w + 48);
      x = w + 49;
      push(32'h1000, 2'd1, x + 1);
      bus_write(4'h4, 32'h2);
      for (int i = 0; i < 4; i++) begin
         wait_until(x + 1 + i);
         src_pc = 32'h2000 + 32'(i);
         push(32'h2000 + 32'(i), 2'd1, x + 2 + i);
      end
      wait_until(x + 5);
      rd_q.push_back(32'hCAFEF00D);
      bus_re = 1'b1;
      bus_write(4'h0, 32'h55AA55AA);
      bus_re = 1'b0;
      wait_until(x + 7);
      bus_read(4'h8, 32'h9);
      bus_read(4'h0, 32'h55AA55AA);

      // Back to auto, then freeze during rotation.
      wait_until(x + 10);
      y = x + 11;
      push(32'h55AA55AA, 2'd0, y + 1);
      push(32'h2003,     2'd1, y + 9);
      bus_write(4'h4, 32'h0);
      wait_until(y + 10);
      f = y + 11;
      bus_write(4'h4, 32'hFFFFFFFC);
      wait_until(f + 1);
      src_pc  = 32'h3000;
      src_dbg = 32'h4444;
      wait_until(f + 3);
      bus_read(4'h4, 32'h4);
      bus_read(4'h8, 32'hD);
      wait_until(f + 20);
      check32("frozen_data", disp_data, 32'h2003);
      check32("frozen_src", 32'(disp_src), 32'h1);
      wait_until(f + 21);
      g = f + 22;
      push(32'h55AA55AA, 2'd0, g + 1);
      push(32'h3000,     2'd1, g + 9);
      bus_write(4'h4, 32'h0);

      // Asynchronous reset in the middle of HOLD.
      wait_until(g + 10);
      h = g + 11;
      push(32'h55AA55AA, 2'd0, h);
      push(32'hA5A5A5A5, 2'd0, h + 1);
      bus_write(4'h0, 32'hA5A5A5A5);
      wait_until(h + 4);
      bus_read(4'h8, 32'h4);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check32("arst_data", disp_data, 32'h0);
      check32("arst_src", 32'(disp_src), 32'h0);
      check32("arst_upd", 32'(disp_upd), 32'h0);
      check32("arst_blank", 32'(disp_blank), 32'h0);
      check32("arst_rdata", bus_rdata, 32'h0);
      repeat (2) tick();
      rst = 1'b1;
      k0 = cyc;
      push(32'h3000, 2'd1, k0 + 8);
      push(32'h4444, 2'd2, k0 + 10);
      wait_until(k0 + 1);
      bus_read(4'hC, 32'h0);
      bus_read(4'h4, 32'h0);
      bus_read(4'h0, 32'h0);
      bus_write(4'hC, 32'hFFFFFFFF);
      bus_read(4'hC, 32'h0);
      // Forced switch to DBG while the PC switch blank is still active.
      wait_until(k0 + 8);
      bus_write(4'h4, 32'h3);
      wait_until(k0 + 20);
      check32("events_drained", 32'(exp_q.size()), 32'd0);
      check32("reads_drained", 32'(rd_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
